// File: rtl/demux_1_8_stream.sv
// demux_1_8_stream: routes one valid/ready input stream to one of 8 registered
// output channels. Optional accepted-transfer counter under DEMUX_1_8_COUNT_EN.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   in_data/select  payload and destination channel (0..7)
//   in_valid/ready  input handshake; ready = selected channel is free
//   out_data        8 slices of N bits, slice k = channel k
//   out_valid/ready per-channel output handshake
//   accept_count    16-bit wrapping count of accepted inputs (macro only)
module demux_1_8_stream #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   in_data,
  input  logic [2:0]     in_select,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [8*N-1:0] out_data,
  output logic [7:0]     out_valid,
  input  logic [7:0]     out_ready
`ifdef DEMUX_1_8_COUNT_EN
  ,
  output logic [15:0]    accept_count
`endif
);

  logic [N-1:0] r_data [8];
  logic [7:0]   r_valid;
  logic [7:0]   w_free;
  logic [7:0]   w_load;
  logic         w_xfer;

  // A channel can take a new beat if empty or draining this cycle.
  assign w_free   = ~r_valid | out_ready;
  assign in_ready = w_free[in_select];
  assign w_xfer   = in_valid & in_ready;
  assign w_load   = w_xfer ? (8'b1 << in_select) : 8'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int k = 0; k < 8; k++)
        r_data[k] <= '0;
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (w_load[k]) begin
          r_data[k]  <= in_data;
          r_valid[k] <= 1'b1;
        end else if (out_ready[k]) begin
          r_valid[k] <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_out
    assign out_data[g*N +: N] = r_data[g];
  end

  assign out_valid = r_valid;

`ifdef DEMUX_1_8_COUNT_EN
  logic [15:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_count <= '0;
    else if (w_xfer)
      r_count <= r_count + 16'd1;
  end

  assign accept_count = r_count;
`endif

endmodule

// File: tb/tb_demux_1_8_stream.sv
// tb_demux_1_8_stream: directed table-driven bench for demux_1_8_stream,
// plus hand-written streaming, reset and sweep sequences.
module tb_demux_1_8_stream;

  localparam int N = 32;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   in_data;
  logic [2:0]     in_select;
  logic           in_valid;
  logic           in_ready;
  logic [8*N-1:0] out_data;
  logic [7:0]     out_valid;
  logic [7:0]     out_ready;
`ifdef DEMUX_1_8_COUNT_EN
  logic [15:0]    accept_count;
`endif

  demux_1_8_stream #(.N(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_select    (in_select),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
`ifdef DEMUX_1_8_COUNT_EN
    ,
    .accept_count (accept_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_run;
  int n_fail;

  typedef struct {
    logic [2:0]   sel;
    logic [N-1:0] data;
    logic         valid;
    logic [7:0]   ordy;
    logic         exp_rdy;
    logic [7:0]   exp_ov;
    int           ch;
    logic [N-1:0] exp_slice;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [N-1:0] slice(int k);
    return out_data[k*N +: N];
  endfunction

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic [2:0] s, logic [N-1:0] d, logic v,
                       logic [7:0] r);
    in_select = s;
    in_data   = d;
    in_valid  = v;
    out_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;

    //       sel  data          v  ordy    rdy ov      ch slice
    vecs[0] = '{3'd5, 32'hDEADBEEF, 1, 8'h00, 1, 8'h20, 5, 32'hDEADBEEF};
    vecs[1] = '{3'd2, 32'h22,       1, 8'h00, 1, 8'h24, 2, 32'h22};
    vecs[2] = '{3'd2, 32'h99,       1, 8'h00, 0, 8'h24, 2, 32'h22};
    vecs[3] = '{3'd3, 32'h33,       1, 8'h00, 1, 8'h2C, 3, 32'h33};
    vecs[4] = '{3'd5, 32'h55,       0, 8'h00, 0, 8'h2C, 5, 32'hDEADBEEF};
    vecs[5] = '{3'd5, 32'h55,       1, 8'h20, 1, 8'h2C, 5, 32'h55};
    vecs[6] = '{3'd0, 32'h77,       0, 8'h04, 1, 8'h28, 0, 32'h0};
    vecs[7] = '{3'd2, 32'hAA,       1, 8'h08, 1, 8'h24, 2, 32'hAA};
    vecs[8] = '{3'd4, 32'h44,       1, 8'h24, 1, 8'h10, 4, 32'h44};

    rst_n = 1'b0;
    drive(3'd0, '0, 1'b0, 8'h00);
    #2;
    chk("reset_ov", 256'(out_valid), 256'h0);
    chk("reset_data", 256'(out_data), 256'h0);
    chk("reset_rdy", 256'(in_ready), 256'h1);
`ifdef DEMUX_1_8_COUNT_EN
    chk("reset_cnt", 256'(accept_count), 256'h0);
`endif
    // valid input across an edge while in reset must not load
    drive(3'd1, 32'h1234, 1'b1, 8'h00);
    tick();
    chk("reset_noload", 256'(out_valid), 256'h0);
    drive(3'd0, '0, 1'b0, 8'h00);
    #2 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].sel, vecs[i].data, vecs[i].valid, vecs[i].ordy);
      #1;
      chk($sformatf("v%0d_rdy", i), 256'(in_ready), 256'(vecs[i].exp_rdy));
      tick();
      chk($sformatf("v%0d_ov", i), 256'(out_valid), 256'(vecs[i].exp_ov));
      chk($sformatf("v%0d_slice", i), 256'(slice(vecs[i].ch)),
          256'(vecs[i].exp_slice));
      if (i == 0)
        chk("single_others", 256'(out_data & ~({N{1'b1}} << (5*N))),
            256'h0);
    end

    // streaming into channel 7 with consumer always ready
    for (int b = 1; b <= 10; b++) begin
      drive(3'd7, N'(b), 1'b1, 8'h80);
      #1;
      chk($sformatf("strm%0d_rdy", b), 256'(in_ready), 256'h1);
      tick();
      chk($sformatf("strm%0d_ov", b), 256'(out_valid), 256'h90);
      chk($sformatf("strm%0d_data", b), 256'(slice(7)), 256'(b));
    end
    drive(3'd7, '0, 1'b0, 8'h80);
    tick();
    chk("strm_drain", 256'(out_valid), 256'h10);
    chk("strm_hold4", 256'(slice(4)), 256'h44);

    // fill channel 0 too, then reset between edges
    drive(3'd0, 32'hC0, 1'b1, 8'h00);
    tick();
    chk("pre_rst_ov", 256'(out_valid), 256'h11);
    drive(3'd0, '0, 1'b0, 8'h00);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_ov", 256'(out_valid), 256'h0);
    chk("mid_rst_data", 256'(out_data), 256'h0);
`ifdef DEMUX_1_8_COUNT_EN
    chk("mid_rst_cnt", 256'(accept_count), 256'h0);
`endif
    tick();
    rst_n = 1'b1;
    tick();

    // sweep all channels full
    for (int k = 0; k < 8; k++) begin
      drive(3'(k), N'(32'h10 + k), 1'b1, 8'h00);
      tick();
    end
    drive(3'd0, '0, 1'b0, 8'h00);
    chk("sweep_ov", 256'(out_valid), 256'hFF);
    for (int k = 0; k < 8; k++)
      chk($sformatf("sweep_s%0d", k), 256'(slice(k)), 256'(32'h10 + k));
    for (int k = 0; k < 8; k++) begin
      drive(3'(k), 32'hBAD, 1'b1, 8'h00);
      #1;
      chk($sformatf("full_rdy%0d", k), 256'(in_ready), 256'h0);
    end
    tick();
    chk("full_hold_s3", 256'(slice(3)), 256'h13);
`ifdef DEMUX_1_8_COUNT_EN
    chk("sweep_cnt", 256'(accept_count), 256'h8);
    rst_n = 1'b0;
    drive(3'd0, 32'h1, 1'b1, 8'hFF);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 65537; c++)
      tick();
    chk("cnt_wrap", 256'(accept_count), 256'h1);
    drive(3'd0, '0, 1'b0, 8'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_1_8_stream.md
DEMUX_1_8_STREAM -- requirements
Module: demux_1_8_stream

Interface
REQ-001 Parameter N, default 32, SHALL set the payload width in bits.
REQ-002 The module SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_data  input  N  payload to route.
REQ-006 in_select  input  3  destination channel index, 0..7.
REQ-007 in_valid  input  1  in_data and in_select are valid this cycle.
REQ-008 in_ready  output  1  module accepts the input this cycle.
REQ-009 out_data  output  8*N  channel k payload occupies bits [k*N +: N].
REQ-010 out_valid  output  8  bit k: channel k holds a payload.
REQ-011 out_ready  input  8  bit k: channel k consumer takes the payload this cycle.
REQ-012 accept_count  output  16  total accepted transfers; present only with DEMUX_1_8_COUNT_EN.

Function
REQ-013 Each channel k SHALL own one output register (data plus valid flag) that drives out_data slice k and out_valid[k].
REQ-014 A channel register SHALL be free when out_valid[k]=0 or out_ready[k]=1 in the same cycle.
REQ-015 in_ready SHALL be combinational and equal to "channel in_select is free". It SHALL NOT depend on other channels.
REQ-016 An input transfer SHALL occur when in_valid=1 and in_ready=1. At that edge the register of channel in_select SHALL load in_data and set its valid flag.
REQ-017 An output transfer on channel k SHALL occur when out_valid[k]=1 and out_ready[k]=1. The valid flag SHALL clear at that edge unless the same channel loads in the same cycle.
REQ-018 A simultaneous output transfer and input load on the same channel SHALL replace the register contents and keep out_valid[k]=1, giving full throughput with no bubble.
REQ-019 Latency from input transfer to out_valid[k] assertion SHALL be exactly 1 cycle.
REQ-020 Channels not selected SHALL hold their data and valid flag, apart from their own output transfers.
REQ-021 When out_valid[k]=1 and out_ready[k]=0, out_data slice k SHALL remain stable.
REQ-022 At most one channel SHALL load per cycle. The data path SHALL contain no combinational path from in_data to out_data.
REQ-023 When in_valid=0, no register SHALL load, whatever the value of in_select.

Reset
REQ-024 When rst_n=0, all out_valid bits SHALL clear to 0 and all out_data slices to 0, immediately and independently of clk.
REQ-025 When rst_n=0, accept_count (if present) SHALL clear to 0.
REQ-026 Reset asserted while a channel is full SHALL discard its payload with no output transfer.
REQ-027 While rst_n=0, in_ready SHALL be 1, because every channel is empty, but no transfer SHALL occur.
REQ-028 Operation SHALL resume on the first rising edge after rst_n deasserts.

Configuration
REQ-029 The macro DEMUX_1_8_COUNT_EN SHALL control accepted-transfer counting.
REQ-030 With DEMUX_1_8_COUNT_EN defined, accept_count SHALL increment by 1 on every input transfer and wrap from 0xFFFF to 0x0000.
REQ-031 Without DEMUX_1_8_COUNT_EN, the accept_count port and its counter SHALL be absent. All other behaviour SHALL be identical.

Verification
REQ-032 Single route: after reset, in_select=5, in_data=0xDEADBEEF, in_valid=1 for one cycle, all out_ready=0 -> next cycle out_valid=8'b0010_0000 and slice 5=0xDEADBEEF; all other slices stay 0.
REQ-033 Backpressure: channel 2 full with out_ready[2]=0, then in_select=2, in_valid=1 -> in_ready=0 and slice 2 unchanged. With in_select=3 instead -> in_ready=1 and channel 3 loads.
REQ-034 Streaming: out_ready[7]=1 held, 10 back-to-back beats to in_select=7 with data 1..10 -> in_ready stays 1 and channel 7 outputs 1..10 on consecutive cycles.
REQ-035 Sweep: in_select=0..7 with data 0x10+k and all out_ready=0 -> out_valid=8'hFF and each slice k=0x10+k; the next input to any channel sees in_ready=0.
REQ-036 Reset mid-operation: channels 0 and 4 full, pulse rst_n low between clock edges -> out_valid=0 and out_data=0 immediately; accept_count=0.
REQ-037 Counter wrap (with DEMUX_1_8_COUNT_EN): 65537 accepted transfers -> accept_count=1. Build without the macro -> port absent and REQ-032 through REQ-036 still pass.
